// File: rtl/instruction_fetch.sv
// Fetch stage: direct-mapped I-cache lookup on pc, miss refill via the memory
// controller, and one {inst, pc} push per cycle into the instruction queue.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    IC_IDX_W   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] jump_pc,
  input  logic                  queue_is_full,
  output logic                  IF_inst_valid,
  output logic [31:0]           IF_inst,
  output logic [ADDR_WIDTH-1:0] IF_pc,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_done,
  input  logic [31:0]           mem_inst
);

  localparam int LINES = 1 << IC_IDX_W;
  localparam int TAG_W = ADDR_WIDTH - IC_IDX_W - 2;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   pc, pc_nxt;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];

  logic                    push, fill, req_valid_nxt;
  logic [ADDR_WIDTH-1:0]   req_addr_nxt;

  logic [IC_IDX_W-1:0]     idx, fidx;
  logic [TAG_W-1:0]        ptag, ftag;
  logic                    hit;

  assign idx  = pc[IC_IDX_W+1:2];
  assign ptag = pc[ADDR_WIDTH-1:IC_IDX_W+2];
  assign fidx = mem_req_addr[IC_IDX_W+1:2];
  assign ftag = mem_req_addr[ADDR_WIDTH-1:IC_IDX_W+2];
  assign hit  = valid[idx] && (tag_mem[idx] == ptag);

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    push          = 1'b0;
    fill          = 1'b0;
    req_valid_nxt = mem_req_valid;
    req_addr_nxt  = mem_req_addr;
    unique case (state)
      IDLE: begin
        if (clear) begin
          pc_nxt = jump_pc;
        end else if (!queue_is_full) begin
          if (hit) begin
            push   = 1'b1;
            pc_nxt = pc + ADDR_WIDTH'(4);
          end else begin
            req_valid_nxt = 1'b1;
            req_addr_nxt  = {pc[ADDR_WIDTH-1:2], 2'b00};
            state_nxt     = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (clear) pc_nxt = jump_pc;
        if (mem_done) begin
          fill          = 1'b1;
          req_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end else if (clear) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The returning word still belongs to mem_req_addr, so it is cached.
        if (clear) pc_nxt = jump_pc;
        if (mem_done) begin
          fill          = 1'b1;
          req_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      valid         <= '0;
      IF_inst_valid <= 1'b0;
      IF_inst       <= '0;
      IF_pc         <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
    end else if (!rdy) begin
      IF_inst_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      mem_req_valid <= req_valid_nxt;
      mem_req_addr  <= req_addr_nxt;
      IF_inst_valid <= push;
      if (push) begin
        IF_inst <= data_mem[idx];
        IF_pc   <= pc;
      end
      if (fill) valid[fidx] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      tag_mem[fidx]  <= ftag;
      data_mem[fidx] <= mem_inst;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory responses are driven by hand
// and every output is compared against hand-computed values.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, queue_is_full, mem_done;
  logic [31:0] jump_pc, mem_inst;
  logic        IF_inst_valid, mem_req_valid;
  logic [31:0] IF_inst, IF_pc, mem_req_addr;

  int errs = 0;
  int checks = 0;

  instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .IC_IDX_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .jump_pc(jump_pc),
    .queue_is_full(queue_is_full), .IF_inst_valid(IF_inst_valid),
    .IF_inst(IF_inst), .IF_pc(IF_pc), .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr), .mem_done(mem_done), .mem_inst(mem_inst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_resp(input logic [31:0] d);
    mem_done = 1'b1;
    mem_inst = d;
    tick();
    mem_done = 1'b0;
    mem_inst = '0;
  endtask

  task automatic chk_push(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_v"}, 32'(IF_inst_valid), 32'd1);
    chk({tag, "_pc"}, IF_pc, a);
    chk({tag, "_inst"}, IF_inst, d);
    chk({tag, "_noreq"}, 32'(mem_req_valid), 32'd0);
  endtask

  // Redirect to a, let the miss go out, and return word d.
  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    clear = 1'b1; jump_pc = a;
    tick();
    clear = 1'b0;
    chk("pre_nopush", 32'(IF_inst_valid), 32'd0);
    tick();
    chk("pre_req", 32'(mem_req_valid), 32'd1);
    chk("pre_addr", mem_req_addr, a);
    mem_resp(d);
  endtask

  function automatic logic [31:0] dw(input logic [31:0] a);
    return 32'hC0DE0000 | a;
  endfunction

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; jump_pc = '0;
    queue_is_full = 1'b0; mem_done = 1'b0; mem_inst = '0;
    tick(); tick();
    chk("rst_v", 32'(IF_inst_valid), 32'd0);
    chk("rst_inst", IF_inst, 32'd0);
    chk("rst_pc", IF_pc, 32'd0);
    chk("rst_req", 32'(mem_req_valid), 32'd0);
    chk("rst_addr", mem_req_addr, 32'd0);
    rst = 1'b0;

    // cold start: miss at 0, memory answers on the third cycle
    tick();
    chk("cold_req", 32'(mem_req_valid), 32'd1);
    chk("cold_addr", mem_req_addr, 32'd0);
    tick(); tick();
    chk("cold_hold", 32'(mem_req_valid), 32'd1);
    chk("cold_hold_addr", mem_req_addr, 32'd0);
    mem_resp(32'h00000013);
    chk("cold_done_req", 32'(mem_req_valid), 32'd0);
    chk("cold_done_v", 32'(IF_inst_valid), 32'd0);
    tick();
    chk_push("cold_push", 32'h0, 32'h00000013);
    tick();
    chk("cold_next_req", 32'(mem_req_valid), 32'd1);
    chk("cold_next_addr", mem_req_addr, 32'h4);
    mem_resp(dw(32'h4));
    preload(32'h8, dw(32'h8));
    preload(32'hC, dw(32'hC));

    // warm loop
    clear = 1'b1; jump_pc = 32'h0;
    tick();
    clear = 1'b0;
    chk("warm_clr_nopush", 32'(IF_inst_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_push("warm", 32'(i * 4), (i == 0) ? 32'h13 : dw(32'(i * 4)));
    end

    // queue full holds pc
    clear = 1'b1; jump_pc = 32'h0;
    tick();
    clear = 1'b0;
    tick();
    chk_push("qf_pre", 32'h0, 32'h13);
    queue_is_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("qf_v", 32'(IF_inst_valid), 32'd0);
      chk("qf_req", 32'(mem_req_valid), 32'd0);
    end
    queue_is_full = 1'b0;
    tick();
    chk_push("qf_resume", 32'h4, dw(32'h4));
    tick();
    chk_push("rdy_pre", 32'h8, dw(32'h8));

    // rdy stall after a hit
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_v", 32'(IF_inst_valid), 32'd0);
    end
    rdy = 1'b1;
    tick();
    chk_push("rdy_resume", 32'hC, dw(32'hC));
    tick();
    chk("rdy_after_v", 32'(IF_inst_valid), 32'd0);
    chk("rdy_after_addr", mem_req_addr, 32'h10);

    // clear during miss at 0x40
    mem_resp(dw(32'h10));
    clear = 1'b1; jump_pc = 32'h40;
    tick();
    clear = 1'b0;
    chk("cm_nopush", 32'(IF_inst_valid), 32'd0);
    tick();
    chk("cm_req", 32'(mem_req_valid), 32'd1);
    chk("cm_addr", mem_req_addr, 32'h40);
    clear = 1'b1; jump_pc = 32'h100;
    tick();
    clear = 1'b0;
    chk("cm_drain_req", 32'(mem_req_valid), 32'd1);
    chk("cm_drain_addr", mem_req_addr, 32'h40);
    tick();
    chk("cm_drain_hold", 32'(mem_req_valid), 32'd1);
    mem_resp(dw(32'h40));
    chk("cm_done_req", 32'(mem_req_valid), 32'd0);
    chk("cm_done_v", 32'(IF_inst_valid), 32'd0);
    tick();
    chk("cm_nopush40", 32'(IF_inst_valid), 32'd0);
    chk("cm_next_req", 32'(mem_req_valid), 32'd1);
    chk("cm_next_addr", mem_req_addr, 32'h100);
    mem_resp(dw(32'h100));
    tick();
    chk_push("cm_push100", 32'h100, dw(32'h100));
    clear = 1'b1; jump_pc = 32'h40;
    tick();
    clear = 1'b0;
    tick();
    chk_push("cm_hit40", 32'h40, dw(32'h40));

    // async reset while waiting on a miss at 0x44
    tick();
    chk("ar_req", 32'(mem_req_valid), 32'd1);
    chk("ar_addr", mem_req_addr, 32'h44);
    #2 rst = 1'b1;
    #1;
    chk("ar_req_drop", 32'(mem_req_valid), 32'd0);
    chk("ar_addr_drop", mem_req_addr, 32'd0);
    chk("ar_v_drop", 32'(IF_inst_valid), 32'd0);
    chk("ar_pc_drop", IF_pc, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_cold_v", 32'(IF_inst_valid), 32'd0);
    chk("ar_cold_req", 32'(mem_req_valid), 32'd1);
    chk("ar_cold_addr", mem_req_addr, 32'd0);

    // clear together with mem_done: fill line 0, redirect to top of memory
    mem_done = 1'b1; mem_inst = 32'h13; clear = 1'b1; jump_pc = 32'hFFFF_FFFC;
    tick();
    mem_done = 1'b0; mem_inst = '0; clear = 1'b0;
    chk("cd_req", 32'(mem_req_valid), 32'd0);
    chk("cd_v", 32'(IF_inst_valid), 32'd0);
    tick();
    chk("wrap_req", 32'(mem_req_valid), 32'd1);
    chk("wrap_addr", mem_req_addr, 32'hFFFF_FFFC);
    mem_resp(32'hDEAD_BEEF);
    tick();
    chk_push("wrap_top", 32'hFFFF_FFFC, 32'hDEAD_BEEF);
    tick();
    chk_push("wrap_zero", 32'h0, 32'h13);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
